// File: rtl/adc_scan_sequencer.sv
// Channel-scan controller for an 8-ch 12-bit SPI ADC using 16-clock frames.
// Defining ADC_SHADOW_REGS_EN adds a per-channel shadow result bank with fresh flags.
module adc_scan_sequencer #(
   parameter int unsigned CLK_DIV = 25
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        start,
   input  logic        continuous,
   input  logic [7:0]  ch_mask,
   output logic        busy,
   output logic        result_valid,
   output logic [2:0]  result_ch,
   output logic [11:0] result_data,
   output logic        adc_sclk,
   output logic        adc_cs_n,
   output logic        adc_din,
   input  logic        adc_dout
`ifdef ADC_SHADOW_REGS_EN
   ,
   input  logic [2:0]  rd_addr,
   input  logic        rd_ack,
   output logic [11:0] rd_data,
   output logic [7:0]  rd_fresh
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      state_q;
   logic [7:0]  div_q, div_d;
   logic        tick_s;
   logic [4:0]  half_q;
   logic [11:0] sr_q;
   logic [7:0]  pend_q;
   logic [2:0]  first_ch_q, cur_ch_q, prev_ch_q;
   logic        prime_q, last_q, bit_done_q;
   logic        busy_q, rv_q, sclk_q, cs_n_q, din_q;
   logic [2:0]  rch_q;
   logic [11:0] rdata_q;
   logic [2:0]  mask_low_s, pend_low_s;
   logic [7:0]  mask_rest_s, pend_rest_s;
   logic [3:0]  next_bit_s;

   function automatic logic [2:0] lowest_ch(input logic [7:0] m);
      logic [2:0] ch;
      ch = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         ch = m[i] ? 3'(i) : ch;
      end
      return ch;
   endfunction

   // Address bits a2..a0 occupy frame bits 2..4; all other DIN bits are zero.
   function automatic logic addr_bit(input logic [2:0] ch, input logic [3:0] idx);
      logic b;
      case (idx)
         4'd2:    b = ch[2];
         4'd3:    b = ch[1];
         4'd4:    b = ch[0];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   always_comb begin
      tick_s = (state_q != ST_IDLE) && (div_q == DIV_LAST);
      if ((state_q == ST_IDLE) || tick_s) begin
         div_d = 8'd0;
      end else begin
         div_d = div_q + 8'd1;
      end
      mask_low_s  = lowest_ch(ch_mask);
      mask_rest_s = ch_mask & ~(8'd1 << mask_low_s);
      pend_low_s  = lowest_ch(pend_q);
      pend_rest_s = pend_q & ~(8'd1 << pend_low_s);
      next_bit_s  = half_q[4:1] + 4'd1;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q    <= ST_IDLE;
         div_q      <= 8'd0;
         half_q     <= 5'd0;
         sr_q       <= 12'd0;
         pend_q     <= 8'd0;
         first_ch_q <= 3'd0;
         cur_ch_q   <= 3'd0;
         prev_ch_q  <= 3'd0;
         prime_q    <= 1'b0;
         last_q     <= 1'b0;
         bit_done_q <= 1'b0;
         busy_q     <= 1'b0;
         rv_q       <= 1'b0;
         rch_q      <= 3'd0;
         rdata_q    <= 12'd0;
         sclk_q     <= 1'b1;
         cs_n_q     <= 1'b1;
         din_q      <= 1'b0;
      end else begin
         div_q      <= div_d;
         rv_q       <= 1'b0;
         bit_done_q <= 1'b0;
         // The prime frame's conversion belongs to no requested channel.
         if (bit_done_q && !prime_q) begin
            rv_q    <= 1'b1;
            rch_q   <= prev_ch_q;
            rdata_q <= sr_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (start && (ch_mask != 8'd0)) begin
                  state_q    <= ST_SETUP;
                  busy_q     <= 1'b1;
                  cs_n_q     <= 1'b0;
                  sclk_q     <= 1'b1;
                  first_ch_q <= mask_low_s;
                  cur_ch_q   <= mask_low_s;
                  pend_q     <= mask_rest_s;
                  prime_q    <= 1'b1;
                  last_q     <= 1'b0;
               end
            end
            ST_SETUP: begin
               if (tick_s) begin
                  state_q <= ST_SHIFT;
                  half_q  <= 5'd0;
                  sclk_q  <= 1'b0;
                  din_q   <= addr_bit(cur_ch_q, 4'd0);
               end
            end
            ST_SHIFT: begin
               if (tick_s) begin
                  if (!half_q[0]) begin
                     sclk_q     <= 1'b1;
                     sr_q       <= {sr_q[10:0], adc_dout};
                     bit_done_q <= (half_q == 5'd30);
                     half_q     <= half_q + 5'd1;
                  end else if (half_q == 5'd31) begin
                     state_q <= ST_HOLD;
                     cs_n_q  <= 1'b1;
                     sclk_q  <= 1'b1;
                     din_q   <= 1'b0;
                  end else begin
                     sclk_q <= 1'b0;
                     din_q  <= addr_bit(cur_ch_q, next_bit_s);
                     half_q <= half_q + 5'd1;
                  end
               end
            end
            ST_HOLD: begin
               if (tick_s) begin
                  if (!last_q) begin
                     state_q   <= ST_SETUP;
                     cs_n_q    <= 1'b0;
                     prev_ch_q <= cur_ch_q;
                     prime_q   <= 1'b0;
                     // Once the list is exhausted, re-address the first channel to flush the pipeline.
                     if (pend_q != 8'd0) begin
                        cur_ch_q <= pend_low_s;
                        pend_q   <= pend_rest_s;
                     end else begin
                        cur_ch_q <= first_ch_q;
                        last_q   <= 1'b1;
                     end
                  end else if (continuous && (ch_mask != 8'd0)) begin
                     state_q    <= ST_SETUP;
                     cs_n_q     <= 1'b0;
                     first_ch_q <= mask_low_s;
                     cur_ch_q   <= mask_low_s;
                     pend_q     <= mask_rest_s;
                     prime_q    <= 1'b1;
                     last_q     <= 1'b0;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign result_valid = rv_q;
   assign result_ch    = rch_q;
   assign result_data  = rdata_q;
   assign adc_sclk     = sclk_q;
   assign adc_cs_n     = cs_n_q;
   assign adc_din      = din_q;

`ifdef ADC_SHADOW_REGS_EN
   logic [11:0] bank_q [8];
   logic [7:0]  fresh_q;

   // A new result outranks a same-cycle acknowledge of that channel.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         for (int i = 0; i < 8; i++) begin
            bank_q[i] <= 12'd0;
         end
         fresh_q <= 8'd0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (rv_q && (rch_q == 3'(i))) begin
               bank_q[i]  <= rdata_q;
               fresh_q[i] <= 1'b1;
            end else if (rd_ack && (rd_addr == 3'(i))) begin
               fresh_q[i] <= 1'b0;
            end
         end
      end
   end

   assign rd_data  = bank_q[rd_addr];
   assign rd_fresh = fresh_q;
`endif

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: behavioural ADC device model plus scan-level expectations.
module tb_adc_scan_sequencer;
   localparam int DIV       = 2;
   localparam int FRAME_CLK = 34 * DIV;
   // SETUP plus 31 half-periods reach the 16th rising SCLK; the strobe follows one clk later.
   localparam int RES_OFS   = 32 * DIV + 1;

   logic        clk_clk = 1'b0;
   logic        reset_reset = 1'b1;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic [7:0]  ch_mask = 8'h00;
   logic        adc_dout = 1'b0;
   logic        busy, result_valid, adc_sclk, adc_cs_n, adc_din;
   logic [2:0]  result_ch;
   logic [11:0] result_data;
`ifdef ADC_SHADOW_REGS_EN
   logic [2:0]  rd_addr = 3'd0;
   logic        rd_ack = 1'b0;
   logic [11:0] rd_data;
   logic [7:0]  rd_fresh;
`endif

   int n_total = 0;
   int n_pass  = 0;
   int cyc = 0;
   int cs_low_cnt = 0;

   adc_scan_sequencer #(.CLK_DIV(DIV)) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start), .continuous(continuous),
      .ch_mask(ch_mask), .busy(busy), .result_valid(result_valid), .result_ch(result_ch),
      .result_data(result_data), .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_din(adc_din),
      .adc_dout(adc_dout)
`ifdef ADC_SHADOW_REGS_EN
      , .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_fresh(rd_fresh)
`endif
   );

   always #5 clk_clk = ~clk_clk;

   // ADC device model: converts in each frame the channel addressed in the previous one.
   int          frame_cnt = 0;
   int          cur_frame = 0;
   int          fall_cnt = 0;
   int          rise_cnt = 0;
   logic [2:0]  addr_latched = 3'd0;
   logic [2:0]  conv_ch = 3'd0;
   logic [15:0] din_sh = 16'h0000;
   logic [15:0] dout_word = 16'h0000;
   logic [15:0] din_word_log[$];

   always @(negedge adc_cs_n) begin
      cur_frame = frame_cnt;
      frame_cnt = frame_cnt + 1;
      conv_ch   = addr_latched;
      dout_word = {4'h0, 12'hA00 | (12'(conv_ch) << 4) | 12'(cur_frame % 16)};
      fall_cnt  = 0;
      rise_cnt  = 0;
      din_sh    = 16'h0000;
   end

   always @(negedge adc_sclk) begin
      if (!adc_cs_n && fall_cnt < 16) begin
         adc_dout = dout_word[15 - fall_cnt];
         fall_cnt = fall_cnt + 1;
      end
   end

   always @(posedge adc_sclk) begin
      if (!adc_cs_n) begin
         din_sh = {din_sh[14:0], adc_din};
         if (rise_cnt == 4) addr_latched = din_sh[2:0];
         if (rise_cnt == 15) din_word_log.push_back(din_sh);
         rise_cnt = rise_cnt + 1;
      end
   end

   // Result and pin monitor.
   logic [2:0]  res_ch_q[$];
   logic [11:0] res_data_q[$];
   int          res_cyc_q[$];

   always @(posedge clk_clk) cyc <= cyc + 1;

   always @(negedge clk_clk) begin
      if (result_valid === 1'b1) begin
         res_ch_q.push_back(result_ch);
         res_data_q.push_back(result_data);
         res_cyc_q.push_back(cyc);
      end
      if (adc_cs_n === 1'b0) cs_low_cnt <= cs_low_cnt + 1;
   end

   task automatic test_reset();
      int r0, cl0;
      reset_reset = 1'b1;
      repeat (3) @(negedge clk_clk);
      reset_reset = 1'b0;
      r0 = res_ch_q.size();
      cl0 = cs_low_cnt;
      repeat (100) @(negedge clk_clk);
      n_total++; if (adc_sclk !== 1'b1) $display("FAIL reset_sclk: got %b want 1", adc_sclk); else n_pass++;
      n_total++; if (adc_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", adc_cs_n); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (adc_din !== 1'b0) $display("FAIL reset_din: got %b want 0", adc_din); else n_pass++;
      n_total++; if (result_valid !== 1'b0) $display("FAIL reset_rv: got %b want 0", result_valid); else n_pass++;
      n_total++; if (result_ch !== 3'd0) $display("FAIL reset_ch: got %0d want 0", result_ch); else n_pass++;
      n_total++; if (result_data !== 12'd0) $display("FAIL reset_data: got %h want 000", result_data); else n_pass++;
      n_total++; if (res_ch_q.size() != r0) $display("FAIL reset_no_results: got %0d want %0d", res_ch_q.size(), r0); else n_pass++;
      n_total++; if (cs_low_cnt != cl0) $display("FAIL reset_cs_idle: got %0d low cycles want 0", cs_low_cnt - cl0); else n_pass++;
   endtask

   task automatic test_scan(input logic [7:0] mask);
      logic [2:0]  lst[$];
      logic [15:0] exp_w;
      logic [11:0] exp_d;
      int n, r0, d0, c0, f0, guard, idx;
      for (int ch = 0; ch < 8; ch++) if (mask[ch]) lst.push_back(3'(ch));
      n  = lst.size();
      r0 = res_ch_q.size();
      d0 = din_word_log.size();
      @(negedge clk_clk);
      ch_mask = mask;
      start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0;
      c0 = cyc;
      f0 = cur_frame;
      ch_mask = 8'($urandom);
      n_total++; if (busy !== 1'b1) $display("FAIL scan_busy_rise: got %b want 1", busy); else n_pass++;
      guard = 0;
      while (busy !== 1'b0 && guard < 2000) begin
         @(negedge clk_clk);
         guard++;
      end
      n_total++;
      if (cyc != c0 + (n + 1) * FRAME_CLK) $display("FAIL scan_busy_len mask=%h: got %0d want %0d", mask, cyc - c0, (n + 1) * FRAME_CLK);
      else n_pass++;
      n_total++;
      if (din_word_log.size() != d0 + n + 1) $display("FAIL scan_frames mask=%h: got %0d want %0d", mask, din_word_log.size() - d0, n + 1);
      else n_pass++;
      for (int k = 0; k <= n; k++) begin
         idx = (k == n) ? 0 : k;
         exp_w = {2'b00, lst[idx], 11'd0};
         n_total++;
         if (d0 + k >= din_word_log.size()) $display("FAIL scan_din mask=%h frame %0d: got none want %h", mask, k, exp_w);
         else if (din_word_log[d0 + k] !== exp_w) $display("FAIL scan_din mask=%h frame %0d: got %h want %h", mask, k, din_word_log[d0 + k], exp_w);
         else n_pass++;
      end
      n_total++;
      if (res_ch_q.size() != r0 + n) $display("FAIL scan_count mask=%h: got %0d want %0d", mask, res_ch_q.size() - r0, n);
      else n_pass++;
      for (int k = 1; k <= n; k++) begin
         exp_d = 12'hA00 | (12'(lst[k - 1]) << 4) | 12'((f0 + k) % 16);
         if (r0 + k - 1 < res_ch_q.size()) begin
            n_total++;
            if (res_ch_q[r0 + k - 1] !== lst[k - 1]) $display("FAIL scan_ch mask=%h #%0d: got %0d want %0d", mask, k, res_ch_q[r0 + k - 1], lst[k - 1]);
            else n_pass++;
            n_total++;
            if (res_data_q[r0 + k - 1] !== exp_d) $display("FAIL scan_data mask=%h #%0d: got %h want %h", mask, k, res_data_q[r0 + k - 1], exp_d);
            else n_pass++;
            n_total++;
            if (res_cyc_q[r0 + k - 1] != c0 + k * FRAME_CLK + RES_OFS) $display("FAIL scan_time mask=%h #%0d: got %0d want %0d", mask, k, res_cyc_q[r0 + k - 1] - c0, k * FRAME_CLK + RES_OFS);
            else n_pass++;
         end
      end
   endtask

   task automatic test_basic_scan();
      test_scan(8'h05);
      test_scan(8'hFF);
      test_scan(8'h80);
   endtask

   task automatic test_random_scans();
      for (int i = 0; i < 4; i++) test_scan(8'($urandom_range(255, 1)));
   endtask

   task automatic test_ignored_start();
      int fr0, r0, cl0, c0, guard;
      fr0 = frame_cnt;
      r0  = res_ch_q.size();
      cl0 = cs_low_cnt;
      @(negedge clk_clk);
      ch_mask = 8'h00;
      start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0;
      repeat (50) @(negedge clk_clk);
      n_total++; if (busy !== 1'b0) $display("FAIL zero_mask_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (cs_low_cnt != cl0) $display("FAIL zero_mask_cs: got %0d low cycles want 0", cs_low_cnt - cl0); else n_pass++;
      @(negedge clk_clk);
      ch_mask = 8'h03;
      start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0;
      c0 = cyc;
      repeat (100) @(negedge clk_clk);
      ch_mask = 8'hFF;
      start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0;
      guard = 0;
      while (busy !== 1'b0 && guard < 2000) begin
         @(negedge clk_clk);
         guard++;
      end
      n_total++; if (cyc != c0 + 3 * FRAME_CLK) $display("FAIL busy_start_len: got %0d want %0d", cyc - c0, 3 * FRAME_CLK); else n_pass++;
      n_total++; if (frame_cnt != fr0 + 3) $display("FAIL busy_start_frames: got %0d want 3", frame_cnt - fr0); else n_pass++;
      n_total++; if (res_ch_q.size() != r0 + 2) $display("FAIL busy_start_results: got %0d want 2", res_ch_q.size() - r0); else n_pass++;
   endtask

   task automatic test_continuous();
      int r0, d0, c0, f0, guard;
      logic [11:0] exp_d;
      r0 = res_ch_q.size();
      d0 = din_word_log.size();
      @(negedge clk_clk);
      ch_mask = 8'h80;
      continuous = 1'b1;
      start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0;
      c0 = cyc;
      f0 = cur_frame;
      guard = 0;
      while (res_ch_q.size() < r0 + 3 && guard < 2000) begin
         @(negedge clk_clk);
         guard++;
      end
      continuous = 1'b0;
      guard = 0;
      while (busy !== 1'b0 && guard < 2000) begin
         @(negedge clk_clk);
         guard++;
      end
      n_total++; if (cyc != c0 + 6 * FRAME_CLK) $display("FAIL cont_busy_len: got %0d want %0d", cyc - c0, 6 * FRAME_CLK); else n_pass++;
      n_total++; if (res_ch_q.size() != r0 + 3) $display("FAIL cont_count: got %0d want 3", res_ch_q.size() - r0); else n_pass++;
      n_total++; if (din_word_log.size() != d0 + 6) $display("FAIL cont_frames: got %0d want 6", din_word_log.size() - d0); else n_pass++;
      for (int s = 0; s < 3; s++) begin
         if (r0 + s < res_ch_q.size()) begin
            exp_d = 12'hA00 | (12'd7 << 4) | 12'((f0 + 2 * s + 1) % 16);
            n_total++; if (res_ch_q[r0 + s] !== 3'd7) $display("FAIL cont_ch #%0d: got %0d want 7", s, res_ch_q[r0 + s]); else n_pass++;
            n_total++; if (res_data_q[r0 + s] !== exp_d) $display("FAIL cont_data #%0d: got %h want %h", s, res_data_q[r0 + s], exp_d); else n_pass++;
            n_total++;
            if (res_cyc_q[r0 + s] != c0 + FRAME_CLK + RES_OFS + s * 2 * FRAME_CLK) $display("FAIL cont_time #%0d: got %0d want %0d", s, res_cyc_q[r0 + s] - c0, FRAME_CLK + RES_OFS + s * 2 * FRAME_CLK);
            else n_pass++;
         end
      end
      // A zero mask at the rescan point ends the run even with continuous held high.
      @(negedge clk_clk);
      ch_mask = 8'h01;
      continuous = 1'b1;
      start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0;
      c0 = cyc;
      ch_mask = 8'h00;
      guard = 0;
      while (busy !== 1'b0 && guard < 2000) begin
         @(negedge clk_clk);
         guard++;
      end
      continuous = 1'b0;
      n_total++; if (cyc != c0 + 2 * FRAME_CLK) $display("FAIL cont_zero_mask_len: got %0d want %0d", cyc - c0, 2 * FRAME_CLK); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      int r0, c0, guard;
      r0 = res_ch_q.size();
      @(negedge clk_clk);
      ch_mask = 8'h0F;
      start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0;
      c0 = cyc;
      guard = 0;
      while (cyc < c0 + FRAME_CLK + DIV + 18 * DIV && guard < 2000) begin
         @(negedge clk_clk);
         guard++;
      end
      n_total++; if (adc_cs_n !== 1'b0 || adc_sclk !== 1'b0) $display("FAIL mid_shift_pins: got cs_n=%b sclk=%b want 0 0", adc_cs_n, adc_sclk); else n_pass++;
      reset_reset = 1'b1;
      @(negedge clk_clk);
      n_total++; if (adc_cs_n !== 1'b1) $display("FAIL mid_reset_cs_n: got %b want 1", adc_cs_n); else n_pass++;
      n_total++; if (adc_sclk !== 1'b1) $display("FAIL mid_reset_sclk: got %b want 1", adc_sclk); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (result_valid !== 1'b0) $display("FAIL mid_reset_rv: got %b want 0", result_valid); else n_pass++;
      reset_reset = 1'b0;
      repeat (100) @(negedge clk_clk);
      n_total++; if (res_ch_q.size() != r0) $display("FAIL mid_reset_results: got %0d want 0", res_ch_q.size() - r0); else n_pass++;
      test_scan(8'h02);
   endtask

`ifdef ADC_SHADOW_REGS_EN
   task automatic test_shadow();
      int f0, guard;
      logic [11:0] exp_d;
      @(negedge clk_clk);
      ch_mask = 8'hFF;
      start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0;
      f0 = cur_frame;
      guard = 0;
      while (busy !== 1'b0 && guard < 2000) begin
         @(negedge clk_clk);
         guard++;
      end
      n_total++; if (rd_fresh !== 8'hFF) $display("FAIL shadow_fresh: got %h want ff", rd_fresh); else n_pass++;
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a);
         #1;
         exp_d = 12'hA00 | (12'(a) << 4) | 12'((f0 + a + 1) % 16);
         n_total++; if (rd_data !== exp_d) $display("FAIL shadow_data addr %0d: got %h want %h", a, rd_data, exp_d); else n_pass++;
      end
      @(negedge clk_clk);
      rd_addr = 3'd3;
      rd_ack = 1'b1;
      @(negedge clk_clk);
      rd_ack = 1'b0;
      n_total++; if (rd_fresh !== 8'hF7) $display("FAIL shadow_ack: got %h want f7", rd_fresh); else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic_scan();
      test_ignored_start();
      test_random_scans();
      test_continuous();
      test_reset_mid_frame();
`ifdef ADC_SHADOW_REGS_EN
      test_shadow();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want bench completion");
      $fatal(1, "bench timeout");
   end

endmodule
